// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N_CH-input valid/ready stream multiplexer with round-robin
// arbitration and a single registered output stage tagged with the source
// channel index.
// Optional packet locking is enabled by defining RR_STREAM_MUX_LOCK_EN; it
// adds in_last/out_last and holds the grant on one channel until its packet ends.
module rr_stream_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef RR_STREAM_MUX_LOCK_EN
  ,
  input  logic [N_CH-1:0]       in_last,
  output logic                  out_last
`endif
);

  localparam int unsigned NCH_U = N_CH;

  logic [WIDTH-1:0] ch_data [N_CH];
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] cand;
  logic             grant_any;
  logic             load;

`ifdef RR_STREAM_MUX_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_ch;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load = !out_valid || out_ready;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_any = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NCH_U; k++) begin
      cand = SEL_W'((32'(last_grant) + k) % NCH_U);
      if (!grant_any && in_valid[cand]) begin
        grant_any = 1'b1;
        grant     = cand;
      end
    end
`ifdef RR_STREAM_MUX_LOCK_EN
    // A locked packet owns the arbiter even while its producer is idle.
    if (lock) begin
      grant_any = in_valid[lock_ch];
      grant     = lock_ch;
    end
`endif
  end

  // Only the granted channel sees ready, and only when the output can load.
  always_comb begin
    in_ready = '0;
    if (grant_any && load) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register and arbiter history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(N_CH - 1);
`ifdef RR_STREAM_MUX_LOCK_EN
      out_last   <= 1'b0;
      lock       <= 1'b0;
      lock_ch    <= '0;
`endif
    end else if (load) begin
      if (grant_any) begin
        out_data   <= ch_data[grant];
        out_ch     <= grant;
        out_valid  <= 1'b1;
        last_grant <= grant;
`ifdef RR_STREAM_MUX_LOCK_EN
        // Lock sets on a non-final beat and clears on the final one.
        out_last   <= in_last[grant];
        lock       <= !in_last[grant];
        lock_ch    <= grant;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux (N_CH=4, WIDTH=8) using a reference
// arbiter model and a scoreboard of expected output beats.
// Define RR_STREAM_MUX_LOCK_EN to also exercise packet locking.
module tb_rr_stream_mux;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int SW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SW-1:0]         out_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_CH-1:0]       in_last;
  logic                  out_last_obs;
`ifdef RR_STREAM_MUX_LOCK_EN
  logic                  out_last;
  assign out_last_obs = out_last;
`else
  assign out_last_obs = 1'b0;
`endif

  rr_stream_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RR_STREAM_MUX_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [SW-1:0]    ch;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t sb[$];
  beat_t b;

  // Reference model state (state after the next rising edge once updated).
  logic          m_ov;
  int            m_lg;
  logic [SW-1:0] m_ch;
  logic [7:0]    m_data;
  logic          m_lock;
  int            m_lock_ch;
  logic          m_load;
  logic          m_got;
  logic [SW-1:0] m_g;
  logic [SW-1:0] c;
  logic [N_CH-1:0] exp_rdy;
  logic          lst;

  // Model: predict in_ready and the next output beat; compare DUT outputs.
  always @(negedge clk) begin
    if (rst) begin
      m_ov = 1'b0; m_lg = N_CH - 1; m_ch = '0; m_data = '0;
      m_lock = 1'b0; m_lock_ch = 0;
      sb.delete();
    end else begin
      m_load = !m_ov || out_ready;
      m_got = 1'b0; m_g = '0;
      for (int s = 1; s <= N_CH; s++) begin
        c = SW'((m_lg + s) % N_CH);
        if (!m_got && in_valid[c] && (!m_lock || int'(c) == m_lock_ch)) begin
          m_got = 1'b1;
          m_g = c;
        end
      end
      exp_rdy = '0;
      if (m_got && m_load) exp_rdy[m_g] = 1'b1;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          b = sb[0];
          check("out_ch", 32'(out_ch), 32'(b.ch));
          check("out_data", 32'(out_data), 32'(b.data));
`ifdef RR_STREAM_MUX_LOCK_EN
          check("out_last", 32'(out_last_obs), 32'(b.last));
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        check("hold_ch", 32'(out_ch), 32'(m_ch));
        check("hold_data", 32'(out_data), 32'(m_data));
      end
      if (m_load) begin
        if (m_got) begin
`ifdef RR_STREAM_MUX_LOCK_EN
          lst = in_last[m_g];
`else
          lst = 1'b1;
`endif
          b.ch = m_g;
          b.data = 8'(in_data >> (32'(m_g) * WIDTH));
          b.last = lst;
          sb.push_back(b);
          m_ov = 1'b1; m_lg = int'(m_g); m_ch = m_g; m_data = b.data;
          m_lock = !lst; m_lock_ch = int'(m_g);
        end else begin
          m_ov = 1'b0;
        end
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  logic [N_CH-1:0] fire;
  int idx;
  logic drop;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; in_last = '1; out_ready = 1'b1;
    cycles(2);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    cycles(3);

    // All channels valid: strict 0,1,2,3 rotation.
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    in_valid = 4'b1111;
    cycles(10);
    in_valid = '0;
    cycles(2);

    // Move last_grant to 2, then only ch0/ch2 valid: wraps to ch0 first.
    in_valid = 4'b0100;
    cycles(1);
    in_valid = 4'b0101;
    cycles(4);
    in_valid = '0;
    cycles(1);

    // Consumer stall for 3 cycles with traffic pending.
    in_valid = 4'b1111;
    cycles(2);
    out_ready = 1'b0;
    cycles(3);
    out_ready = 1'b1;
    cycles(3);

    // Reset while holding a beat; ch0 and ch1 valid on release.
    in_valid = 4'b0010;
    cycles(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_valid", 32'(out_valid), 0);
    check("rst_async_ch", 32'(out_ch), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 4'b0011;
    cycles(2);
    // Reset again with only ch1 valid.
    do_reset();
    in_valid = 4'b0010;
    cycles(3);
    in_valid = '0;
    cycles(2);

`ifdef RR_STREAM_MUX_LOCK_EN
    // ch1 packet of 3 beats with a gap while ch0/ch2 keep requesting.
    do_reset();
    in_last = '1;
    in_valid = 4'b0101;
    idx = 0; drop = 1'b0;
    for (int n = 0; n < 12; n++) begin
      in_valid[1] = (idx < 3) && !drop;
      in_last[1] = (idx == 2);
      in_data[15:8] = 8'(8'h50 + idx);
      @(negedge clk);
      fire = in_valid & in_ready;
      drop = 1'b0;
      if (fire[1]) begin
        idx++;
        if (idx == 1) drop = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("ch1_beats", idx, 3);
    in_valid = '0;
    cycles(2);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor to the 2:1 combinational mux.
- N_CH-input, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Round-robin arbitration between requesting channels; the result is held in a single output register tagged with the source channel index.
- Sits between several producer streams and one consumer, for example merging sample streams onto a shared bus.

Parameters:
- N_CH, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data width per channel in bits; must be at least 1.
- Derived localparam SEL_W = $clog2(N_CH); not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready; at most one bit high per cycle
- out_data  output  WIDTH  registered data
- out_ch  output  SEL_W  registered source channel index of out_data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, last_grant=N_CH-1, so channel 0 has top priority first.
- Output register state:
  - load = !out_valid || out_ready.
  - A beat transfers on an input when in_valid[i] && in_ready[i].
  - The output completes a transfer when out_valid && out_ready.
- Arbitration (combinational, this cycle):
  - Search order starts at (last_grant+1) mod N_CH and wraps through all N_CH channels.
  - The first channel with in_valid=1 is granted.
  - in_ready[g] = load for the granted channel g; all other in_ready bits are 0.
  - With no in_valid set, all in_ready bits are 0.
  - in_ready depends combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- On a clock edge with load=1:
  - Grant present: out_data<=in_data[g], out_ch<=g, out_valid<=1, last_grant<=g.
  - No grant: out_valid<=0. out_data and out_ch hold their previous values.
- On a clock edge with load=0 (out_valid=1, out_ready=0): all outputs and last_grant hold, and every in_ready bit is 0 (stall).
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 beat per cycle while out_ready=1. There are no bubbles between back-to-back grants.
- Fairness: with all channels continuously valid and out_ready=1, the grant sequence is 0,1,...,N_CH-1,0,... Each channel waits at most N_CH-1 beats.
- Wrap-around: if last_grant=N_CH-1, the search starts at channel 0.
- A valid input must hold in_data stable until its beat transfers. The block does not check this.
- Reset mid-operation discards any held beat (out_valid drops immediately) and returns the arbiter to the reset priority.

Optional Feature:
- Macro: RR_STREAM_MUX_LOCK_EN.
- Defined:
  - Adds ports in_last (input, N_CH) and out_last (output, 1, registered, reset 0). out_last is loaded alongside out_data.
  - Adds a lock flag (reset 0) and lock_ch (reset 0).
  - When a granted beat transfers with in_last[g]=0: lock<=1, lock_ch<=g.
  - While lock=1, only lock_ch may be granted; other channels are ignored even if lock_ch is not valid.
  - A transfer from lock_ch with in_last=1 clears lock. last_grant updates as normal.
  - Packets from different channels are therefore never interleaved.
- Undefined: in_last, out_last and the lock logic are absent, and arbitration is decided per beat.

Test Plan:
- Reset, then all channels idle -> out_valid=0, out_data=0, out_ch=0, in_ready=0; out_data and out_ch hold through idle cycles.
- N_CH=4, WIDTH=8, all in_valid=1 with data 0x10,0x21,0x32,0x43, out_ready=1 -> out_ch sequence 0,1,2,3,0, one per cycle; out_data matches the source channel; each beat appears 1 cycle after its input transfer.
- Only ch2 and ch0 valid, starting from last_grant=2 -> grant goes to ch0 first (wrap-around), then ch2, then ch0.
- out_ready held 0 for 3 cycles with out_valid=1 -> out_data, out_ch and out_valid stable; in_ready=0000. On release, the next channel in round-robin order loads in the same cycle.
- rst pulsed while out_valid=1 and ch1 valid -> out_valid=0 immediately; after release ch0 wins if it is valid, otherwise ch1.
- RR_STREAM_MUX_LOCK_EN defined: ch1 sends 3 beats with last=0,0,1 while ch0 and ch2 are continuously valid, and ch1 drops valid for 1 cycle mid-packet -> out_ch=1,1,1 with no ch0/ch2 beat inserted; ch2 is granted next, and out_last=1 only on the third beat.
